// File: rtl/uart_msg_pkg.sv
// Shared constants for the UART message scheduler: message ids, FSM states,
// per-message lengths and the constant ASCII message ROM.
package uart_msg_pkg;

    localparam int NUM_MSG = 6;
    localparam int MAX_LEN = 8;
    localparam int ID_W    = $clog2(NUM_MSG);
    localparam int IDX_W   = $clog2(MAX_LEN);

    typedef enum logic [ID_W-1:0] {
        MSG_QSTICK  = 3'd0,
        MSG_GOLDEN  = 3'd1,
        MSG_SODAPOP = 3'd2,
        MSG_PAUSE   = 3'd3,
        MSG_RESTART = 3'd4,
        MSG_RESET   = 3'd5
    } msg_id_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Lengths include the trailing newline byte.
    localparam logic [IDX_W:0] MSG_LEN [NUM_MSG] = '{
        4'd7, 4'd7, 4'd8, 4'd6, 4'd8, 4'd6
    };

    localparam logic [7:0] MSG_ROM [NUM_MSG][MAX_LEN] = '{
        '{8'h71, 8'h73, 8'h74, 8'h69, 8'h63, 8'h6B, 8'h0A, 8'h00},
        '{8'h67, 8'h6F, 8'h6C, 8'h64, 8'h65, 8'h6E, 8'h0A, 8'h00},
        '{8'h73, 8'h6F, 8'h64, 8'h61, 8'h70, 8'h6F, 8'h70, 8'h0A},
        '{8'h70, 8'h61, 8'h75, 8'h73, 8'h65, 8'h0A, 8'h00, 8'h00},
        '{8'h72, 8'h65, 8'h73, 8'h74, 8'h61, 8'h72, 8'h74, 8'h0A},
        '{8'h72, 8'h65, 8'h73, 8'h65, 8'h74, 8'h0A, 8'h00, 8'h00}
    };

endpackage

// File: rtl/uart_msg_scheduler_if.sv
// TX FIFO push port between the message scheduler and the UART controller.
interface uart_msg_scheduler_if;

    // Handshake: tx_push is only raised while tx_full is low, so every cycle
    // with tx_push=1 transfers tx_push_data into the FIFO; no further ack.
    logic       tx_push;
    logic [7:0] tx_push_data;
    logic       tx_full;

    modport master (output tx_push, output tx_push_data, input tx_full);
    modport slave  (input tx_push, input tx_push_data, output tx_full);

endinterface

// File: rtl/uart_msg_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// index of the highest set bit.
module uart_msg_prio_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);

    assign valid = |req;

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Latches message requests and streams the highest-priority pending message
// byte by byte from the ROM onto the UART TX FIFO push port.
module uart_msg_scheduler
    import uart_msg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_MSG-1:0]   msg_req,
    uart_msg_scheduler_if.master tx,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_msg,
    output logic                 msg_done,
    output logic [NUM_MSG-1:0]   pending,
    output state_e               dbg_state
);

    state_e             state;
    logic [IDX_W-1:0]   idx;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               grant;
    logic               push;
    logic               last_byte;
    logic [NUM_MSG-1:0] clear_mask;

    uart_msg_prio_enc #(.N(NUM_MSG), .W(ID_W)) u_prio (
        .req   (pending),
        .valid (grant_valid),
        .idx   (grant_id)
    );

    assign grant     = (state == IDLE) && grant_valid;
    assign push      = (state == SEND) && !tx.tx_full;
    assign last_byte = ({1'b0, idx} == (MSG_LEN[cur_msg] - 1'b1));

    always_comb begin
        clear_mask = '0;
        if (grant) begin
            clear_mask[grant_id] = 1'b1;
        end
    end

    assign tx.tx_push      = push;
    assign tx.tx_push_data = (state == SEND) ? MSG_ROM[cur_msg][idx] : 8'h00;
    assign busy            = (state != IDLE);
    assign msg_done        = (state == DONE);
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            cur_msg <= '0;
            pending <= '0;
        end else begin
            // A new request at the same edge as its grant re-arms the bit.
            pending <= (pending & ~clear_mask) | msg_req;
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_msg <= grant_id;
                        idx     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (push) begin
                        if (last_byte) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Directed bench for uart_msg_scheduler: a per-cycle vector table for a single
// message plus hand-written sequences for priority, stalls, re-arm and reset.
module tb_uart_msg_scheduler;
    import uart_msg_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] msg_req;
    logic       busy;
    logic [2:0] cur_msg;
    logic       msg_done;
    logic [5:0] pending;
    state_e     dbg_state;

    uart_msg_scheduler_if tx_if ();

    uart_msg_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .msg_req   (msg_req),
        .tx        (tx_if),
        .busy      (busy),
        .cur_msg   (cur_msg),
        .msg_done  (msg_done),
        .pending   (pending),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         push_cyc[$];

    logic       s_push;
    logic [7:0] s_data;
    logic       s_busy;
    logic       s_done;
    logic [5:0] s_pending;
    logic [2:0] s_cur;

    typedef struct {
        logic [5:0] req;
        logic       full;
        logic       push;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic [5:0] pend;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, sample settled outputs 1ns later.
    task automatic step(input logic [5:0] req, input logic full, input logic rst);
        @(negedge clk);
        msg_req        = req;
        tx_if.tx_full  = full;
        reset          = rst;
        #1;
        s_push    = tx_if.tx_push;
        s_data    = tx_if.tx_push_data;
        s_busy    = busy;
        s_done    = msg_done;
        s_pending = pending;
        s_cur     = cur_msg;
        if (s_push === 1'b1) begin
            got_q.push_back(s_data);
            push_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        push_cyc.delete();
    endtask

    task automatic run_until_idle(input string name);
        int n;
        n = 0;
        do begin
            step(6'b0, 1'b0, 1'b0);
            n++;
        end while ((s_busy !== 1'b0 || s_pending !== 6'b0) && n < 200);
        chk({name, " drain_timeout"}, 32'(n < 200), 32'd1);
    endtask

    task automatic check_stream(input string name);
        int n;
        chk({name, " byte_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s byte[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        reset         = 1'b1;
        msg_req       = '0;
        tx_if.tx_full = 1'b0;

        // Single qstick request, idle FIFO: cycle-by-cycle expectations.
        vecs[0]  = '{6'b000001, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{6'b000000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000001};
        vecs[2]  = '{6'b000000, 1'b0, 1'b1, 8'h71, 1'b1, 1'b0, 6'b000000};
        vecs[3]  = '{6'b000000, 1'b0, 1'b1, 8'h73, 1'b1, 1'b0, 6'b000000};
        vecs[4]  = '{6'b000000, 1'b0, 1'b1, 8'h74, 1'b1, 1'b0, 6'b000000};
        vecs[5]  = '{6'b000000, 1'b0, 1'b1, 8'h69, 1'b1, 1'b0, 6'b000000};
        vecs[6]  = '{6'b000000, 1'b0, 1'b1, 8'h63, 1'b1, 1'b0, 6'b000000};
        vecs[7]  = '{6'b000000, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0, 6'b000000};
        vecs[8]  = '{6'b000000, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0, 6'b000000};
        vecs[9]  = '{6'b000000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 6'b000000};
        vecs[10] = '{6'b000000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 6'b000000};

        // Reset state
        step(6'b0, 1'b0, 1'b1);
        step(6'b0, 1'b0, 1'b1);
        chk("rst tx_push", 32'(s_push), 32'd0);
        chk("rst tx_data", 32'(s_data), 32'd0);
        chk("rst busy", 32'(s_busy), 32'd0);
        chk("rst msg_done", 32'(s_done), 32'd0);
        chk("rst pending", 32'(s_pending), 32'd0);
        chk("rst cur_msg", 32'(s_cur), 32'd0);

        // Test 1: table-driven single message
        clear_sb();
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].req, vecs[i].full, 1'b0);
            chk($sformatf("t1[%0d] push", i), 32'(s_push), 32'(vecs[i].push));
            chk($sformatf("t1[%0d] data", i), 32'(s_data), 32'(vecs[i].data));
            chk($sformatf("t1[%0d] busy", i), 32'(s_busy), 32'(vecs[i].busy));
            chk($sformatf("t1[%0d] done", i), 32'(s_done), 32'(vecs[i].done));
            chk($sformatf("t1[%0d] pend", i), 32'(s_pending), 32'(vecs[i].pend));
        end

        // Test 2: pause and golden in the same cycle; pause first
        clear_sb();
        step(6'b001010, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        chk("t2 pending both", 32'(s_pending), 32'h0A);
        step(6'b0, 1'b0, 1'b0);
        chk("t2 pending golden", 32'(s_pending), 32'h02);
        chk("t2 cur_msg pause", 32'(s_cur), 32'd3);
        run_until_idle("t2");
        chk("t2 pending end", 32'(s_pending), 32'd0);
        add_str("pause");
        add_str("golden");
        check_stream("t2");
        if (push_cyc.size() == 13) begin
            chk("t2 pause span", 32'(push_cyc[5] - push_cyc[0]), 32'd5);
            chk("t2 gap", 32'(push_cyc[6] - push_cyc[5]), 32'd3);
        end

        // Test 3: reset request during sodapop byte 3, no preemption
        clear_sb();
        step(6'b000100, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(6'b0, 1'b0, 1'b0);
        step(6'b100000, 1'b0, 1'b0);
        chk("t3 idx3 data", 32'(s_data), 32'h61);
        chk("t3 idx3 cur_msg", 32'(s_cur), 32'd2);
        run_until_idle("t3");
        add_str("sodapop");
        add_str("reset");
        check_stream("t3");

        // Test 4: tx_full stall at restart idx 2
        clear_sb();
        step(6'b010000, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(6'b0, 1'b1, 1'b0);
            chk($sformatf("t4 stall[%0d] push", i), 32'(s_push), 32'd0);
            chk($sformatf("t4 stall[%0d] data", i), 32'(s_data), 32'h73);
            chk($sformatf("t4 stall[%0d] busy", i), 32'(s_busy), 32'd1);
        end
        run_until_idle("t4");
        add_str("restart");
        check_stream("t4");

        // Test 5: re-request of the message in flight plus duplicates
        clear_sb();
        step(6'b000001, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        step(6'b000001, 1'b0, 1'b0);
        step(6'b000001, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        chk("t5 rearmed", 32'(s_pending), 32'h01);
        step(6'b000001, 1'b0, 1'b0);
        step(6'b000001, 1'b0, 1'b0);
        run_until_idle("t5");
        add_str("qstick");
        add_str("qstick");
        check_stream("t5");

        // Test 6: reset in the middle of pause, with golden pending
        clear_sb();
        step(6'b001000, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        step(6'b000010, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        chk("t6 pending golden", 32'(s_pending), 32'h02);
        step(6'b0, 1'b0, 1'b1);
        chk("t6 idx3 data", 32'(s_data), 32'h73);
        step(6'b0, 1'b0, 1'b0);
        chk("t6 post push", 32'(s_push), 32'd0);
        chk("t6 post busy", 32'(s_busy), 32'd0);
        chk("t6 post pending", 32'(s_pending), 32'd0);
        chk("t6 post cur_msg", 32'(s_cur), 32'd0);
        step(6'b001000, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        step(6'b0, 1'b0, 1'b0);
        chk("t6 restart push", 32'(s_push), 32'd1);
        chk("t6 restart data", 32'(s_data), 32'h70);
        run_until_idle("t6");
        exp_q.push_back(8'h70);
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h75);
        exp_q.push_back(8'h73);
        add_str("pause");
        check_stream("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
